// File: rtl/lift_pkg.sv
// Shared types and constants for the 5/3 lifting sequencer.
// Sample/result widths, flag layout, flag codes and FSM states.
package lift_pkg;

  localparam int SW = 9;
  localparam int RW = 10;

  localparam int F_VALID = 2;
  localparam int F_FWD   = 1;
  localparam int F_PRED  = 0;

  localparam logic [2:0] FL_FWD_PRED =
    3'((1 << F_VALID) | (1 << F_FWD) | (1 << F_PRED));
  localparam logic [2:0] FL_FWD_UPD =
    3'((1 << F_VALID) | (1 << F_FWD));
  localparam logic [2:0] FL_INV_PRED =
    3'((1 << F_VALID) | (1 << F_PRED));
  localparam logic [2:0] FL_INV_UPD =
    3'(1 << F_VALID);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1_ISSUE,
    S_P1_WAIT,
    S_P2_ISSUE,
    S_P2_WAIT,
    S_DONE
  } state_t;

  function automatic logic [2:0] mk_flags(
    input logic fwd,
    input logic pred
  );
    logic [2:0] f;
    unique case ({fwd, pred})
      2'b11:   f = FL_FWD_PRED;
      2'b10:   f = FL_FWD_UPD;
      2'b01:   f = FL_INV_PRED;
      default: f = FL_INV_UPD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lift_line_buf.sv
// One-line sample store: one write port, three async reads
// for the operand triplet, one registered read for readback.
module lift_line_buf
  import lift_pkg::*;
#(
  parameter int W  = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [SW-1:0] wdata,
  input  logic [AW-1:0] ra_l,
  input  logic [AW-1:0] ra_s,
  input  logic [AW-1:0] ra_r,
  output logic [SW-1:0] rd_l,
  output logic [SW-1:0] rd_s,
  output logic [SW-1:0] rd_r,
  input  logic [AW-1:0] rd_addr,
  output logic [SW-1:0] rd_data
);

  logic [SW-1:0] mem [W];

  // sample storage, deliberately not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rd_l = mem[ra_l];
  assign rd_s = mem[ra_s];
  assign rd_r = mem[ra_r];

  // registered coefficient readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lift_window_seq.sv
// Line sequencer feeding lift_step with mirrored triplets.
// Optional watchdog abort: define LIFT_SEQ_TIMEOUT_EN.
module lift_window_seq
  import lift_pkg::*;
#(
  parameter int W   = 16,
  parameter int AW  = 4,
  parameter int TMO = 64
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [SW-1:0] pix_i,
  input  logic          start_i,
  input  logic          fwd_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [2:0]    flags_o,
  output logic          update_o,
  output logic [SW-1:0] left_o,
  output logic [SW-1:0] sam_o,
  output logic [SW-1:0] right_o,
  input  logic [RW-1:0] res_i,
  input  logic          res_vld_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [SW-1:0] rd_data_o
);

  localparam logic [AW-1:0] ONE  = AW'(1);
  localparam logic [AW-1:0] TWO  = AW'(2);
  localparam logic [AW-1:0] LAST = AW'(W - 1);
  localparam logic [AW-1:0] PEN  = AW'(W - 2);

  state_t        state;
  logic          fwd;
  logic [AW-1:0] idx;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ra_l;
  logic [AW-1:0] ra_r;
  logic [SW-1:0] rd_l;
  logic [SW-1:0] rd_s;
  logic [SW-1:0] rd_r;
  logic          in_wait;
  logic          pred;
  logic          we;
  logic [AW-1:0] waddr;
  logic [SW-1:0] wdata;
  logic          unused_res;

  // result is wrapped to the sample width on write-back
  assign unused_res = res_i[RW-1];

  assign in_wait = (state == S_P1_WAIT) ||
                   (state == S_P2_WAIT);
  // phase 1 predicts when forward, phase 2 the opposite
  assign pred = (state == S_P1_ISSUE) ? fwd : ~fwd;

  assign we = (in_wait && res_vld_i) ||
              (state == S_IDLE && load_i && !start_i);
  assign waddr = in_wait ? idx : ptr;
  assign wdata = in_wait ? res_i[SW-1:0] : pix_i;

  // symmetric extension at both line ends
  always_comb begin
    ra_l = idx - ONE;
    ra_r = idx + ONE;
    if (idx == '0)   ra_l = ONE;
    if (idx == LAST) ra_r = PEN;
  end

  lift_line_buf #(
    .W  (W),
    .AW (AW)
  ) u_buf (
    .clk     (clk_i),
    .rst_n   (rst_n_i),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ra_l    (ra_l),
    .ra_s    (idx),
    .ra_r    (ra_r),
    .rd_l    (rd_l),
    .rd_s    (rd_s),
    .rd_r    (rd_r),
    .rd_addr (rd_addr_i),
    .rd_data (rd_data_o)
  );

`ifdef LIFT_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);
  logic [CW-1:0] tmo_cnt;
  logic          err;
  assign err_o = err;
`else
  localparam int unused_tmo = TMO;
  assign err_o = 1'b0;
`endif

  // sequencing FSM with registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= S_IDLE;
      fwd      <= 1'b0;
      idx      <= '0;
      ptr      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      update_o <= 1'b0;
      flags_o  <= '0;
      left_o   <= '0;
      sam_o    <= '0;
      right_o  <= '0;
`ifdef LIFT_SEQ_TIMEOUT_EN
      tmo_cnt  <= '0;
      err      <= 1'b0;
`endif
    end else begin
      update_o <= 1'b0;
      done_o   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            fwd    <= fwd_i;
            idx    <= fwd_i ? ONE : '0;
            ptr    <= '0;
            busy_o <= 1'b1;
            state  <= S_P1_ISSUE;
`ifdef LIFT_SEQ_TIMEOUT_EN
            err    <= 1'b0;
`endif
          end else if (load_i) begin
            ptr <= (ptr == LAST) ? '0 : ptr + ONE;
          end
        end
        S_P1_ISSUE, S_P2_ISSUE: begin
          left_o   <= rd_l;
          sam_o    <= rd_s;
          right_o  <= rd_r;
          flags_o  <= mk_flags(fwd, pred);
          update_o <= 1'b1;
          state    <= (state == S_P1_ISSUE) ?
                      S_P1_WAIT : S_P2_WAIT;
`ifdef LIFT_SEQ_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end
        S_P1_WAIT, S_P2_WAIT: begin
          if (res_vld_i) begin
            if (idx >= PEN) begin
              if (state == S_P1_WAIT) begin
                idx   <= fwd ? '0 : ONE;
                state <= S_P2_ISSUE;
              end else begin
                done_o  <= 1'b1;
                busy_o  <= 1'b0;
                flags_o <= '0;
                state   <= S_DONE;
              end
            end else begin
              idx   <= idx + TWO;
              state <= (state == S_P1_WAIT) ?
                       S_P1_ISSUE : S_P2_ISSUE;
            end
          end
`ifdef LIFT_SEQ_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            err     <= 1'b1;
            busy_o  <= 1'b0;
            flags_o <= '0;
            state   <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
`endif
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lift_window_seq.sv
// Scoreboard bench for lift_window_seq with a 5/3 lift model.
// Timeout scenario is built when LIFT_SEQ_TIMEOUT_EN is defined.
module tb_lift_window_seq;

  localparam int W  = 16;
  localparam int AW = 4;
`ifdef LIFT_SEQ_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  typedef struct packed {
    logic [2:0] fl;
    logic [8:0] l;
    logic [8:0] s;
    logic [8:0] r;
  } iss_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [8:0]    pix;
  logic          start;
  logic          fwd;
  logic          busy;
  logic          done;
  logic          err;
  logic [2:0]    flags;
  logic          upd;
  logic [8:0]    left;
  logic [8:0]    sam;
  logic [8:0]    right;
  logic [9:0]    res;
  logic          res_vld;
  logic [AW-1:0] rd_addr;
  logic [8:0]    rd_data;

  iss_t       exp_q[$];
  logic [8:0] mbuf[W];
  logic [8:0] orig[W];
  logic [8:0] src[W];
  int         n_vec = 0;
  int         n_err = 0;

  lift_window_seq #(
    .W   (W),
    .AW  (AW),
    .TMO (TMO)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .load_i    (load),
    .pix_i     (pix),
    .start_i   (start),
    .fwd_i     (fwd),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err),
    .flags_o   (flags),
    .update_o  (upd),
    .left_o    (left),
    .sam_o     (sam),
    .right_o   (right),
    .res_i     (res),
    .res_vld_i (res_vld),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  function automatic logic [9:0] lift_m(
    input logic [2:0] f,
    input logic [8:0] l,
    input logic [8:0] s,
    input logic [8:0] r
  );
    int li, si, ri, p, u, o;
    li = int'($signed(l));
    si = int'($signed(s));
    ri = int'($signed(r));
    p = (li + ri) >>> 1;
    u = (li + ri + 2) >>> 2;
    case (f[1:0])
      2'b11:   o = si - p;
      2'b10:   o = si + u;
      2'b00:   o = si - u;
      default: o = si + p;
    endcase
    return 10'(o);
  endfunction

  task automatic model_seq(input logic f);
    logic pr;
    int   st;
    iss_t e;
    for (int ph = 0; ph < 2; ph++) begin
      pr = (ph == 0) ? f : ~f;
      st = pr ? 1 : 0;
      for (int i = st; i < W; i += 2) begin
        e.fl = {1'b1, f, pr};
        e.l  = (i == 0) ? mbuf[1] : mbuf[i-1];
        e.r  = (i == W-1) ? mbuf[W-2] : mbuf[i+1];
        e.s  = mbuf[i];
        exp_q.push_back(e);
        mbuf[i] = 9'(lift_m(e.fl, e.l, e.s, e.r));
      end
    end
  endtask

  task automatic load_all();
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      load = 1'b1;
      pix  = src[i];
      mbuf[i] = src[i];
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start(input logic f);
    @(negedge clk);
    start = 1'b1;
    fwd   = f;
    model_seq(f);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_upd(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (upd === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic run_line(input int dly, input bit stray);
    int         cyc, hs;
    bit         fin;
    iss_t       e, snap;
    logic [9:0] r;
    cyc = 0; hs = 0; fin = 1'b0;
    while (!fin && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      res_vld = 1'b0; start = 1'b0; load = 1'b0;
      if (done === 1'b1) begin
        n_vec++;
        if (busy !== 1'b0 || hs != W || exp_q.size() != 0) begin
          n_err++;
          $display("FAIL done_state: busy=%0b hs=%0d q=%0d, want busy=0 hs=%0d q=0",
                   busy, hs, exp_q.size(), W);
        end
        fin = 1'b1;
      end else if (upd === 1'b1) begin
        snap = {flags, left, sam, right};
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_issue: got %h, none expected", snap);
        end else begin
          e = exp_q.pop_front();
          if (snap !== e) begin
            n_err++;
            $display("FAIL issue%0d: got fl=%0d l=%h s=%h r=%h, want fl=%0d l=%h s=%h r=%h",
                     hs, snap.fl, snap.l, snap.s, snap.r, e.fl, e.l, e.s, e.r);
          end
        end
        if (hs == 0) begin
          n_vec++;
          if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_run: got %b want 1", busy);
          end
        end
        r = lift_m(flags, left, sam, right);
        for (int k = 0; k < dly; k++) begin
          @(negedge clk);
          cyc++;
          n_vec++;
          if (upd !== 1'b0 || {flags, left, sam, right} !== snap) begin
            n_err++;
            $display("FAIL hold%0d: upd=%b ops=%h, want upd=0 ops=%h",
                     k, upd, {flags, left, sam, right}, snap);
          end
        end
        res = r; res_vld = 1'b1; hs++;
        if (hs == 1) begin
          start = 1'b1; fwd = ~fwd; load = 1'b1; pix = 9'h0AA;
        end
        if (stray && hs < W) begin
          @(negedge clk);
          cyc++;
          start = 1'b0; load = 1'b0;
          res = ~r; res_vld = 1'b1;
        end
      end
    end
    if (!fin) begin
      n_vec++; n_err++;
      $display("FAIL run_timeout: no done_o after %0d cycles", cyc);
    end
    res_vld = 1'b0; start = 1'b0; load = 1'b0;
  endtask

  task automatic check_line(input string tag, input bit vs_orig);
    logic [8:0] q[$];
    logic [8:0] x;
    for (int i = 0; i < W; i++) q.push_back(vs_orig ? orig[i] : mbuf[i]);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      rd_addr = AW'(i);
      @(negedge clk);
      x = q.pop_front();
      n_vec++;
      if (rd_data !== x) begin
        n_err++;
        $display("FAIL %s buf[%0d]: got %h want %h", tag, i, rd_data, x);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, err, upd} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_ctrl: got %b want 0000", {busy, done, err, upd});
    end
    n_vec++;
    if (flags !== 3'd0) begin
      n_err++;
      $display("FAIL rst_flags: got %0d want 0", flags);
    end
    n_vec++;
    if ({left, sam, right, rd_data} !== 36'd0) begin
      n_err++;
      $display("FAIL rst_data: got %h want 0", {left, sam, right, rd_data});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({busy, done, err, upd, flags} !== 7'd0) begin
      n_err++;
      $display("FAIL idle_after_rst: got %b want 0", {busy, done, err, upd, flags});
    end
  endtask

  task automatic test_first_issue();
    bit ok;
    for (int i = 0; i < W; i++) src[i] = 9'd0;
    src[0] = 9'd68; src[1] = 9'd218; src[2] = 9'd163;
    load_all();
    do_start(1'b1);
    exp_q.delete();
    wait_upd(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL first_issue: no update_o seen");
      return;
    end
    n_vec++;
    if ({flags, left, sam, right} !== {3'd7, 9'd68, 9'd218, 9'd163}) begin
      n_err++;
      $display("FAIL first_ops: got fl=%0d l=%0d s=%0d r=%0d want 7 68 218 163",
               flags, left, sam, right);
    end
    @(negedge clk);
    n_vec++;
    if (upd !== 1'b0 || {flags, left, sam, right} !== {3'd7, 9'd68, 9'd218, 9'd163}) begin
      n_err++;
      $display("FAIL first_pulse: upd=%b ops=%h, want upd=0 stable", upd,
               {flags, left, sam, right});
    end
    res = 10'h3D6; res_vld = 1'b1;
    @(negedge clk);
    res_vld = 1'b0;
    rd_addr = AW'(1);
    wait_upd(ok);
    n_vec++;
    if (!ok || {flags, left, sam, right} !== {3'd7, 9'd163, 9'd0, 9'd0}) begin
      n_err++;
      $display("FAIL second_ops: seen=%b fl=%0d l=%0d s=%0d r=%0d want 7 163 0 0",
               ok, flags, left, sam, right);
    end
    n_vec++;
    if (rd_data !== 9'h1D6) begin
      n_err++;
      $display("FAIL writeback: buf[1]=%h want 1d6", rd_data);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, done, err, upd, flags, left, sam, right, rd_data} !== 43'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %h want 0",
               {busy, done, err, upd, flags, left, sam, right, rd_data});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy, done, upd, flags} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_idle: got %b want 0", {busy, done, upd, flags});
    end
  endtask

  task automatic test_forward_const();
    for (int i = 0; i < W; i++) src[i] = 9'd100;
    for (int i = 0; i < W; i++) orig[i] = 9'd100;
    load_all();
    do_start(1'b1);
    run_line(0, 1'b0);
    check_line("fwd_const", 1'b0);
    n_vec++;
    if (rd_data !== 9'd0) begin
      n_err++;
      $display("FAIL fwd_const_odd: buf[%0d]=%0d want 0", W-1, rd_data);
    end
  endtask

  task automatic test_inverse();
    do_start(1'b0);
    run_line(0, 1'b0);
    check_line("inv_const", 1'b1);
  endtask

  task automatic test_random_roundtrip();
    for (int i = 0; i < W; i++) begin
      src[i] = 9'(int'($urandom_range(0, 200)) - 100);
      orig[i] = src[i];
    end
    load_all();
    do_start(1'b1);
    run_line(5, 1'b1);
    check_line("rnd_fwd", 1'b0);
    do_start(1'b0);
    run_line(0, 1'b0);
    check_line("rnd_inv", 1'b1);
  endtask

  task automatic test_protocol();
    for (int i = 0; i < W; i++) src[i] = 9'(3 * i + 5);
    load_all();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load = 1'b1;
      pix  = 9'(40 + 7 * i);
      mbuf[i] = pix;
    end
    @(negedge clk);
    load = 1'b1; pix = 9'h055; start = 1'b1; fwd = 1'b1;
    model_seq(1'b1);
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    run_line(0, 1'b1);
    check_line("proto", 1'b0);
    @(negedge clk);
    load = 1'b1; pix = 9'h011;
    @(negedge clk);
    load = 1'b0; rd_addr = AW'(0);
    @(negedge clk);
    n_vec++;
    if (rd_data !== 9'h011) begin
      n_err++;
      $display("FAIL ptr_cleared: buf[0]=%h want 011", rd_data);
    end
  endtask

`ifdef LIFT_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    for (int i = 0; i < W; i++) src[i] = 9'(i);
    load_all();
    do_start(1'b1);
    exp_q.delete();
    wait_upd(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL tmo_issue: no update_o seen");
    end
    for (int k = 2; k <= TMO; k++) begin
      @(negedge clk);
      n_vec++;
      if (err !== 1'b0 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL tmo_early%0d: err=%b busy=%b want 0 1", k, err, busy);
      end
    end
    @(negedge clk);
    n_vec++;
    if ({err, busy, flags} !== {1'b1, 1'b0, 3'd0}) begin
      n_err++;
      $display("FAIL tmo_abort: err=%b busy=%b fl=%0d want 1 0 0", err, busy, flags);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || err !== 1'b1) begin
        n_err++;
        $display("FAIL tmo_hold%0d: done=%b err=%b want 0 1", k, done, err);
      end
    end
    do_start(1'b1);
    exp_q.delete();
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_clear: err=%b want 0", err);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n = 1'b0; load = 1'b0; pix = '0;
    start = 1'b0; fwd = 1'b0;
    res = '0; res_vld = 1'b0; rd_addr = '0;
    test_reset();
    test_first_issue();
    test_reset_mid();
    test_forward_const();
    test_inverse();
    test_random_roundtrip();
    test_protocol();
`ifdef LIFT_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lift_window_seq.md
Name: lift_window_seq

Overview:
- Upstream sequencer for the lift_step 5/3 lifting datapath.
- Buffers one line of W 9-bit samples and issues left/sam/right triplets with flags and an update strobe.
- Captures each lift_step result and writes it back in place, so the second lifting phase consumes first-phase results.
- Whole-line forward (predict→update) or inverse (update→predict) transform; coefficients are read back through a random-access port.

Parameters:
- W, 16, line length in samples; must be even and ≥4.
- AW, 4, address width; equals clog2(W).
- TMO, 64, watchdog limit in cycles; used only with LIFT_SEQ_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- load_i  in  1  write pix_i at the load pointer.
- pix_i  in  9  sample to load.
- start_i  in  1  begin transform of the buffered line.
- fwd_i  in  1  direction, sampled on start_i: 1=forward, 0=inverse.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse when the line is complete.
- err_o  out  1  watchdog abort flag; constant 0 without the macro.
- flags_o  out  3  to lift_step flags_i.
- update_o  out  1  to lift_step update_i.
- left_o  out  9  to lift_step left_i.
- sam_o  out  9  to lift_step sam_i.
- right_o  out  9  to lift_step right_i.
- res_i  in  10  from lift_step res_o (signed).
- res_vld_i  in  1  from lift_step update_o.
- rd_addr_i  in  AW  coefficient read address.
- rd_data_o  out  9  buf[rd_addr_i], registered, 1-cycle latency.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; load pointer 0.
- Line buffer buf[0..W-1] is not reset.
- States and transitions:
  - IDLE: on start_i, latch fwd_i, go to PHASE1_ISSUE. Otherwise, load_i writes buf[ptr] and ptr wraps W-1→0.
  - start_i and load_i in the same cycle: start wins, the load is dropped, ptr is cleared.
  - load_i outside IDLE is ignored.
  - PHASE1_ISSUE → PHASE1_WAIT → PHASE2_ISSUE → PHASE2_WAIT → DONE → IDLE.
- Phase order and indices:
  - Forward: phase1 = predict over odd indices 1,3,…,W-1; phase2 = update over even indices 0,2,…,W-2.
  - Inverse: phase1 = update over even indices; phase2 = predict over odd indices.
- Flags:
  - flags_o[2]=1 while issuing or waiting, else 0.
  - flags_o[1]=latched fwd.
  - flags_o[0]=1 for predict, 0 for update.
  - Resulting codes: forward predict 7, forward update 6, inverse predict 5, inverse update 4.
- Operands for index i, with symmetric extension:
  - sam=buf[i].
  - left=buf[i-1]; at i=0 use buf[1].
  - right=buf[i+1]; at i=W-1 use buf[W-2].
- ISSUE state:
  - Operands and flags are registered.
  - update_o is high for exactly one cycle.
  - Next state is WAIT.
  - Operands and flags stay stable until res_vld_i.
- WAIT state:
  - On res_vld_i, write res_i[8:0] to buf[i] (two's-complement wrap to the lift_step input width).
  - Then i+=2. If the phase is finished, switch phase; otherwise return to ISSUE.
  - Minimum of 2 cycles per index, plus the lift_step latency.
- res_vld_i outside WAIT is ignored.
- start_i while busy is ignored.
- DONE: done_o pulses for one cycle, busy_o drops in the same cycle, then IDLE.
- rd_addr_i reads are allowed at any time. During busy, the returned data may be mid-transform.
- Reset mid-operation: immediate return to IDLE with outputs zero. A pending res_vld_i is lost. Buffer contents are undefined.

Optional Feature:
- Macro: LIFT_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs in each WAIT state.
  - If res_vld_i has not arrived after TMO cycles, the FSM aborts to IDLE with no done_o pulse.
  - err_o is set and held until the next accepted start_i or reset.
- Undefined: no counter; WAIT waits indefinitely; err_o is tied 0.

Decomposition:
- Shared package lift_pkg:
  - Sample width 9 and result width 10.
  - Flag bit positions: VALID=2, FWD=1, PRED=0.
  - Flag codes 7/6/5/4.
  - FSM state encoding.
- Sub-module lift_line_buf: W×9 register array with one write port, three combinational read ports for left/sam/right, and one registered read port for rd_data_o.
- Boundary mirroring and the FSM stay in lift_window_seq.

Test Plan:
- Load W=16 with buf[0..2]=68,218,163, rest 0; start with fwd=1. First issue must be flags=7, left=68, sam=218, right=163, update_o one cycle. Bench model returns res=-0x2A (10'h3D6), which must be written as buf[1]=9'h1D6.
- Full forward line, constant input 100, model = real 5/3 arithmetic: odd coefficients 0, even coefficients 100, done_o after 16 handshakes, busy_o low on the same cycle.
- Inverse (fwd=0) on a forward result: first issue flags=4 at i=0 with left=right=buf[1]; final buffer equals the original samples.
- Boundaries: the i=W-1 predict has right=buf[W-2]; the i=0 update has left=buf[1].
- Protocol: start_i with load_i in IDLE drops the load. A stray res_vld_i in ISSUE causes no write. Delaying res_vld_i 5 cycles holds operands stable. rst_n_i low in PHASE1_WAIT returns to IDLE with all outputs 0.
- With LIFT_SEQ_TIMEOUT_EN and TMO=8, withholding res_vld_i gives err_o=1 at cycle 8 of WAIT, return to IDLE, and no done_o; the next start_i clears err_o.
